// File: rtl/sync_fifo_pkg.sv
// rtl/sync_fifo_pkg.sv - pointer-width helper and parameter legality checks for sync_fifo_param
package sync_fifo_pkg;

  // Pointers carry one extra wrap bit so all DEPTH entries are usable.
  function automatic int ptr_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

  function automatic bit is_pow2(input int value);
    return (value > 0) && ((value & (value - 1)) == 0);
  endfunction

  function automatic bit params_ok(input int depth, input int ae_level, input int af_level);
    return (depth >= 2) && is_pow2(depth) && (ae_level < af_level) && (af_level <= depth);
  endfunction

endpackage

// File: rtl/fifo_mem.sv
// rtl/fifo_mem.sv - simple dual-port RAM, synchronous write, registered read with enable
module fifo_mem #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  parameter int AW     = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_d, rdata_q;

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  always_comb begin
    rdata_d = rdata_q;
    if (re) begin
      rdata_d = mem_q[raddr];
    end
  end

  // Only the output register is reset; the array keeps whatever it held.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata_q <= '0;
    end else begin
      rdata_q <= rdata_d;
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/sync_fifo_param.sv
// rtl/sync_fifo_param.sv - parametrised single-clock FIFO; SYNC_FIFO_ERR_EN adds sticky overflow/underflow
module sync_fifo_param
  import sync_fifo_pkg::*;
#(
  parameter int  DATA_W   = 8,
  parameter int  DEPTH    = 16,
  parameter int  AF_LEVEL = DEPTH - 2,
  parameter int  AE_LEVEL = 2,
  localparam int AW       = ptr_w(DEPTH) - 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              full,
  output logic              empty,
  output logic              almost_full,
  output logic              almost_empty,
  output logic [AW:0]       count
`ifdef SYNC_FIFO_ERR_EN
  ,
  input  logic              err_clr,
  output logic              overflow,
  output logic              underflow
`endif
);

  localparam logic [AW:0] AF_L = (AW+1)'(AF_LEVEL);
  localparam logic [AW:0] AE_L = (AW+1)'(AE_LEVEL);

  if (!params_ok(DEPTH, AE_LEVEL, AF_LEVEL)) begin : g_param_err
    $error("sync_fifo_param: illegal DEPTH/AE_LEVEL/AF_LEVEL combination");
  end

  logic [AW:0] wptr_d, wptr_q;
  logic [AW:0] rptr_d, rptr_q;
  logic        rd_valid_d, rd_valid_q;
  logic        wr_acc, rd_acc;

  assign empty        = (wptr_q == rptr_q);
  assign full         = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign count        = wptr_q - rptr_q;
  assign almost_full  = (count >= AF_L);
  assign almost_empty = (count <= AE_L);

  // Flags come from registered pointers, so full blocks a same-cycle write
  // and empty blocks a same-cycle read: no pass-through, no bypass.
  assign wr_acc = wr_en && !full;
  assign rd_acc = rd_en && !empty;

  always_comb begin
    wptr_d     = wptr_q;
    rptr_d     = rptr_q;
    rd_valid_d = rd_acc;
    if (wr_acc) begin
      wptr_d = wptr_q + 1'b1;
    end
    if (rd_acc) begin
      rptr_d = rptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  assign rd_valid = rd_valid_q;

  fifo_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .AW     (AW)
  ) u_mem (
    .clk   (clk),
    .rst   (rst),
    .we    (wr_acc),
    .waddr (wptr_q[AW-1:0]),
    .wdata (wr_data),
    .re    (rd_acc),
    .raddr (rptr_q[AW-1:0]),
    .rdata (rd_data)
  );

`ifdef SYNC_FIFO_ERR_EN
  logic overflow_d, overflow_q;
  logic underflow_d, underflow_q;

  // A new error in the same cycle as err_clr wins, so no event is lost.
  always_comb begin
    overflow_d  = (overflow_q  && !err_clr) || (wr_en && full);
    underflow_d = (underflow_q && !err_clr) || (rd_en && empty);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  assign overflow  = overflow_q;
  assign underflow = underflow_q;
`endif

endmodule

// File: tb/tb_sync_fifo_param.sv
// tb/tb_sync_fifo_param.sv - scoreboard bench for sync_fifo_param with a queue-based reference model
module tb_sync_fifo_param;

  localparam int DATA_W = 8;
  localparam int DEPTH  = 16;
  localparam int AF     = DEPTH - 2;
  localparam int AE     = 2;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              wr_en = 1'b0;
  logic [DATA_W-1:0] wr_data = '0;
  logic              rd_en = 1'b0;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;
  logic              full, empty, almost_full, almost_empty;
  logic [4:0]        count;
`ifdef SYNC_FIFO_ERR_EN
  logic              err_clr = 1'b0;
  logic              overflow, underflow;
`endif

  int npass = 0;
  int ntot  = 0;

  logic [DATA_W-1:0] model[$];
  logic [DATA_W-1:0] exp_q[$];
  bit                exp_rv = 1'b0;

  sync_fifo_param #(
    .DATA_W   (DATA_W),
    .DEPTH    (DEPTH),
    .AF_LEVEL (AF),
    .AE_LEVEL (AE)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .wr_en        (wr_en),
    .wr_data      (wr_data),
    .rd_en        (rd_en),
    .rd_data      (rd_data),
    .rd_valid     (rd_valid),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .count        (count)
`ifdef SYNC_FIFO_ERR_EN
    ,
    .err_clr      (err_clr),
    .overflow     (overflow),
    .underflow    (underflow)
`endif
  );

  always #5 clk = ~clk;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    ntot++;
    if (act === exp) npass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endfunction

  // Monitor: every rd_valid pops the next expected word from the scoreboard.
  always @(negedge clk) begin
    if (!rst) begin
      check("rd_valid", 32'(rd_valid), 32'(exp_rv));
      if (rd_valid) begin
        if (exp_q.size() == 0) begin
          ntot++;
          $display("FAIL rd_data: got 0x%0h, expected no read", rd_data);
        end else begin
          check("rd_data", 32'(rd_data), 32'(exp_q.pop_front()));
        end
      end
    end
  end

  task automatic check_status();
    check("count", 32'(count), 32'(model.size()));
    check("empty", 32'(empty), 32'(model.size() == 0));
    check("full", 32'(full), 32'(model.size() == DEPTH));
    check("almost_full", 32'(almost_full), 32'(model.size() >= AF));
    check("almost_empty", 32'(almost_empty), 32'(model.size() <= AE));
  endtask

  task automatic step(input bit wr, input logic [DATA_W-1:0] wd, input bit rd);
    bit racc, wacc;
    wr_en = wr; wr_data = wd; rd_en = rd;
    racc = rd && (model.size() != 0);
    wacc = wr && (model.size() != DEPTH);
    if (racc) exp_q.push_back(model.pop_front());
    if (wacc) model.push_back(wd);
    @(posedge clk);
    exp_rv = racc;
    #1;
    wr_en = 1'b0; rd_en = 1'b0;
    check_status();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    model.delete();
    exp_q.delete();
    exp_rv = 1'b0;
    #2;
    check("rst_count", 32'(count), 32'd0);
    check("rst_empty", 32'(empty), 32'd1);
    check("rst_rd_valid", 32'(rd_valid), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("reset_rd_data", 32'(rd_data), 32'd0);
    do_reset();
    step(1'b0, '0, 1'b0);
    check("idle_rd_data", 32'(rd_data), 32'd0);

    // Fill 0x00..0x0F, one rejected extra write, then drain in order.
    for (int i = 0; i < DEPTH; i++) step(1'b1, DATA_W'(i), 1'b0);
    step(1'b1, 8'hAA, 1'b0);
    for (int i = 0; i < DEPTH; i++) step(1'b0, '0, 1'b1);
    step(1'b0, '0, 1'b0);

    // Steady occupancy of 10 across two pointer wraps.
    for (int i = 0; i < 10; i++) step(1'b1, DATA_W'($urandom), 1'b0);
    for (int i = 0; i < 40; i++) step(1'b1, DATA_W'($urandom), 1'b1);
    check("steady_count", 32'(count), 32'd10);

    // Simultaneous read/write at full, then at empty.
    while (model.size() < DEPTH) step(1'b1, DATA_W'($urandom), 1'b0);
    step(1'b1, 8'h5A, 1'b1);
    check("full_rw_count", 32'(count), 32'd15);
    while (model.size() > 0) step(1'b0, '0, 1'b1);
    step(1'b0, '0, 1'b0);
    step(1'b1, 8'hC3, 1'b1);
    check("empty_rw_count", 32'(count), 32'd1);
    step(1'b0, '0, 1'b0);
    check("empty_rw_no_valid", 32'(rd_valid), 32'd0);
    step(1'b0, '0, 1'b1);
    step(1'b0, '0, 1'b0);

    // Mid-stream reset with a read in flight.
    while (model.size() < 7) step(1'b1, DATA_W'($urandom), 1'b0);
    step(1'b0, '0, 1'b1);
    do_reset();
    check_status();
    for (int i = 0; i < 4; i++) step(1'b1, DATA_W'($urandom), 1'b0);
    for (int i = 0; i < 4; i++) step(1'b0, '0, 1'b1);

`ifdef SYNC_FIFO_ERR_EN
    step(1'b0, '0, 1'b0);
    check("underflow_init", 32'(underflow), 32'd0);
    step(1'b0, '0, 1'b1);
    for (int i = 0; i < 5; i++) begin
      step(1'b0, '0, 1'b0);
      check("underflow_sticky", 32'(underflow), 32'd1);
    end
    err_clr = 1'b1;
    step(1'b0, '0, 1'b0);
    err_clr = 1'b0;
    check("underflow_clr", 32'(underflow), 32'd0);
    while (model.size() < DEPTH) step(1'b1, DATA_W'($urandom), 1'b0);
    check("overflow_init", 32'(overflow), 32'd0);
    step(1'b1, 8'hEE, 1'b0);
    check("overflow_set", 32'(overflow), 32'd1);
    err_clr = 1'b1;
    step(1'b1, 8'hEF, 1'b0);
    err_clr = 1'b0;
    check("overflow_clr_vs_event", 32'(overflow), 32'd1);
`endif

    // Random traffic against the reference model.
    for (int i = 0; i < 400; i++) begin
      step(1'($urandom_range(0, 1)), DATA_W'($urandom), 1'($urandom_range(0, 1)));
    end
    while (model.size() > 0) step(1'b0, '0, 1'b1);
    step(1'b0, '0, 1'b0);
    @(negedge clk);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
